// File: rtl/mem_instr_arbiter.sv
// Round-robin arbiter sharing the data-cache memory unit's single instruction port.
// One instruction in flight: accept, one-cycle issue pulse, then track busy/idle with a timeout.
module mem_instr_arbiter #(
  parameter int NUM_REQ           = 2,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int LINE_WIDTH        = 96,
  parameter int TIMEOUT_CYCLES    = 64
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic [NUM_REQ*INSTRUCTION_WIDTH-1:0] req_instr_in,
  input  logic [NUM_REQ-1:0]                   req_valid_in,
  output logic [NUM_REQ-1:0]                   req_ready_out,
  output logic [INSTRUCTION_WIDTH-1:0]         mem_instr_out,
  output logic                                 mem_instr_valid_out,
  input  logic                                 mem_idle_in,
  input  logic [LINE_WIDTH-1:0]                mem_abc_in,
  input  logic                                 mem_abc_valid_in,
  output logic [LINE_WIDTH-1:0]                resp_abc_out,
  output logic [NUM_REQ-1:0]                   resp_valid_out,
  output logic [NUM_REQ-1:0]                   grant_out,
  output logic                                 busy_out,
  output logic                                 timeout_err_out
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_IDLE
  } state_t;

  state_t                         state_q, state_d;
  logic [PTR_W-1:0]               rr_ptr_q, rr_ptr_d;
  logic [INSTRUCTION_WIDTH-1:0]   instr_q, instr_d;
  logic [NUM_REQ-1:0]             grant_q, grant_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [LINE_WIDTH-1:0]          resp_abc_q, resp_abc_d;
  logic [NUM_REQ-1:0]             resp_vld_q, resp_vld_d;
  logic                           timeout_q, timeout_d;

  logic                           found;
  int                             sel_idx;
  logic [PTR_W-1:0]               winner;
  logic [NUM_REQ-1:0]             winner_oh;
  logic [INSTRUCTION_WIDTH-1:0]   winner_instr;
  logic [PTR_W-1:0]               winner_next;
  logic                           accept;
  logic                           in_wait;
  logic                           timing_out;

  function automatic logic is_mem_op(input logic [3:0] op);
    case (op)
      4'b0110, 4'b0111, 4'b1000, 4'b1001: is_mem_op = 1'b1;
      default:                            is_mem_op = 1'b0;
    endcase
  endfunction

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    found   = 1'b0;
    winner  = '0;
    sel_idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sel_idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!found && req_valid_in[sel_idx]) begin
        found  = 1'b1;
        winner = PTR_W'(sel_idx);
      end
    end
  end

  always_comb begin
    winner_oh         = '0;
    winner_oh[winner] = 1'b1;
    winner_instr      = req_instr_in[int'(winner)*INSTRUCTION_WIDTH +: INSTRUCTION_WIDTH];
    if (winner == PTR_W'(NUM_REQ - 1)) begin
      winner_next = '0;
    end else begin
      winner_next = winner + 1'b1;
    end
  end

  // Reset is folded in so no accept is advertised while the block is held in reset.
  assign accept  = !rst_in && (state_q == ST_IDLE) && mem_idle_in && found;
  assign in_wait = (state_q == ST_WAIT_BUSY) || (state_q == ST_WAIT_IDLE);

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    instr_d    = instr_q;
    grant_d    = grant_q;
    cnt_d      = cnt_q;
    resp_abc_d = resp_abc_q;
    resp_vld_d = '0;
    timeout_d  = timeout_q;
    timing_out = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          instr_d  = winner_instr;
          rr_ptr_d = winner_next;
          if (is_mem_op(winner_instr[INSTRUCTION_WIDTH-1 -: 4])) begin
            grant_d = winner_oh;
            state_d = ST_ISSUE;
          end else begin
            grant_d = '0;
          end
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY, ST_WAIT_IDLE: begin
        if ((state_q == ST_WAIT_IDLE) && mem_idle_in) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timing_out = 1'b1;
          timeout_d  = 1'b1;
          state_d    = ST_IDLE;
          grant_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if ((state_q == ST_WAIT_BUSY) && !mem_idle_in) begin
            state_d = ST_WAIT_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase

    // grant_q still names the owner on the completing cycle, so a coincident line is delivered.
    if (in_wait && mem_abc_valid_in && !timing_out) begin
      resp_abc_d = mem_abc_in;
      resp_vld_d = grant_q;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      instr_q    <= '0;
      grant_q    <= '0;
      cnt_q      <= '0;
      resp_abc_q <= '0;
      resp_vld_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      instr_q    <= instr_d;
      grant_q    <= grant_d;
      cnt_q      <= cnt_d;
      resp_abc_q <= resp_abc_d;
      resp_vld_q <= resp_vld_d;
      timeout_q  <= timeout_d;
    end
  end

  assign req_ready_out       = accept ? winner_oh : '0;
  assign mem_instr_out       = instr_q;
  assign mem_instr_valid_out = (state_q == ST_ISSUE);
  assign grant_out           = grant_q;
  assign busy_out            = (state_q != ST_IDLE);
  assign resp_abc_out        = resp_abc_q;
  assign resp_valid_out      = resp_vld_q;
  assign timeout_err_out     = timeout_q;

endmodule

// File: tb/tb_mem_instr_arbiter.sv
// Directed bench for mem_instr_arbiter: reset, issue/handshake, round robin, responses, drop, timeout.
module tb_mem_instr_arbiter;
  localparam int NR = 2;
  localparam int IW = 32;
  localparam int LW = 96;
  localparam int TO = 64;

  logic           clk_in = 1'b0;
  logic           rst_in = 1'b0;
  logic [NR*IW-1:0] req_instr_in = '0;
  logic [NR-1:0]  req_valid_in = '0;
  logic [NR-1:0]  req_ready_out;
  logic [IW-1:0]  mem_instr_out;
  logic           mem_instr_valid_out;
  logic           mem_idle_in = 1'b1;
  logic [LW-1:0]  mem_abc_in = '0;
  logic           mem_abc_valid_in = 1'b0;
  logic [LW-1:0]  resp_abc_out;
  logic [NR-1:0]  resp_valid_out;
  logic [NR-1:0]  grant_out;
  logic           busy_out;
  logic           timeout_err_out;

  int errors = 0;
  int checks = 0;
  int pulse_cnt = 0;

  localparam logic [LW-1:0] LINE_A5 = 96'hA5A5A5A5_A5A5A5A5_A5A5A5A5;
  localparam logic [LW-1:0] LINE_CO = 96'h01234567_89ABCDEF_00112233;

  mem_instr_arbiter #(
    .NUM_REQ(NR), .INSTRUCTION_WIDTH(IW), .LINE_WIDTH(LW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .req_instr_in(req_instr_in), .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
    .mem_instr_out(mem_instr_out), .mem_instr_valid_out(mem_instr_valid_out),
    .mem_idle_in(mem_idle_in), .mem_abc_in(mem_abc_in), .mem_abc_valid_in(mem_abc_valid_in),
    .resp_abc_out(resp_abc_out), .resp_valid_out(resp_valid_out),
    .grant_out(grant_out), .busy_out(busy_out), .timeout_err_out(timeout_err_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
    if (mem_instr_valid_out) pulse_cnt++;
  endtask

  // Bounded wait for an accept; an expired bound is a failed comparison.
  task automatic wait_ready(input string name);
    int n = 0;
    while (req_ready_out == '0 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (req_ready_out == '0) begin
      errors++;
      $display("FAIL %s_wait_ready: req_ready_out=%b, required nonzero within 20 cycles", name, req_ready_out);
    end
  endtask

  // Memory drops idle one cycle after the issue pulse and raises it two cycles later.
  task automatic mem_complete();
    tick(); mem_idle_in = 1'b0;
    tick();
    tick(); mem_idle_in = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_in = 1'b1; mem_idle_in = 1'b1; req_valid_in = '0;
    #1;
    checks++; if ({req_ready_out, mem_instr_valid_out, resp_valid_out, grant_out, busy_out, timeout_err_out} !== '0) begin
      errors++; $display("FAIL reset_ctrl: got %b required 0", {req_ready_out, mem_instr_valid_out, resp_valid_out, grant_out, busy_out, timeout_err_out}); end
    checks++; if (mem_instr_out !== '0) begin errors++; $display("FAIL reset_instr: got %h required 0", mem_instr_out); end
    checks++; if (resp_abc_out !== '0) begin errors++; $display("FAIL reset_abc: got %h required 0", resp_abc_out); end
    @(negedge clk_in); rst_in = 1'b0;
    tick();
    pulse_cnt = 0;
    repeat (20) tick();
    checks++; if (pulse_cnt != 0) begin errors++; $display("FAIL idle_no_pulse: got %0d pulses required 0", pulse_cnt); end
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b required 0", busy_out); end
  endtask

  task automatic test_single_sma();
    req_instr_in[0 +: IW] = 32'h6001_2300; req_valid_in = 2'b01; #1;
    wait_ready("sma");
    pulse_cnt = 0;
    checks++; if (req_ready_out !== 2'b01) begin errors++; $display("FAIL sma_ready: got %b required 01", req_ready_out); end
    tick();
    req_valid_in = '0;
    checks++; if (mem_instr_valid_out !== 1'b1) begin errors++; $display("FAIL sma_pulse: got %b required 1", mem_instr_valid_out); end
    checks++; if (mem_instr_out !== 32'h6001_2300) begin errors++; $display("FAIL sma_instr: got %h required 60012300", mem_instr_out); end
    checks++; if (grant_out !== 2'b01) begin errors++; $display("FAIL sma_grant_issue: got %b required 01", grant_out); end
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) mem_idle_in = 1'b0;
      if (k == 3) mem_idle_in = 1'b1;
      if (k < 4) begin
        checks++; if (grant_out !== 2'b01 || busy_out !== 1'b1) begin
          errors++; $display("FAIL sma_grant_c%0d: got grant=%b busy=%b required grant=01 busy=1", k, grant_out, busy_out); end
      end
    end
    checks++; if (busy_out !== 1'b0 || grant_out !== 2'b00) begin
      errors++; $display("FAIL sma_done: got busy=%b grant=%b required busy=0 grant=00", busy_out, grant_out); end
    repeat (3) tick();
    checks++; if (pulse_cnt != 1) begin errors++; $display("FAIL sma_pulse_count: got %0d required 1", pulse_cnt); end
  endtask

  task automatic test_round_robin();
    int exp_order [4] = '{0, 1, 0, 1};
    logic [NR-1:0] want;
    logic [IW-1:0] want_instr;
    rst_in = 1'b1; #2; rst_in = 1'b0;
    req_instr_in[0 +: IW] = 32'h6000_00A0;
    req_instr_in[IW +: IW] = 32'h7000_00B1;
    req_valid_in = 2'b11; #1;
    for (int t = 0; t < 4; t++) begin
      want = (exp_order[t] == 0) ? 2'b01 : 2'b10;
      want_instr = (exp_order[t] == 0) ? 32'h6000_00A0 : 32'h7000_00B1;
      wait_ready("rr");
      checks++; if (req_ready_out !== want) begin errors++; $display("FAIL rr_ready_t%0d: got %b required %b", t, req_ready_out, want); end
      tick();
      checks++; if (req_ready_out !== 2'b00) begin errors++; $display("FAIL rr_ready_len_t%0d: got %b required 00", t, req_ready_out); end
      checks++; if (grant_out !== want || mem_instr_out !== want_instr) begin
        errors++; $display("FAIL rr_grant_t%0d: got grant=%b instr=%h required grant=%b instr=%h", t, grant_out, mem_instr_out, want, want_instr); end
      mem_complete();
    end
    req_valid_in = '0;
  endtask

  task automatic test_writeb_response();
    req_instr_in[IW +: IW] = 32'h9000_0042; req_valid_in = 2'b10; #1;
    wait_ready("wrb");
    checks++; if (req_ready_out !== 2'b10) begin errors++; $display("FAIL wrb_ready: got %b required 10", req_ready_out); end
    tick();
    req_valid_in = '0;
    checks++; if (grant_out !== 2'b10) begin errors++; $display("FAIL wrb_grant: got %b required 10", grant_out); end
    tick(); mem_idle_in = 1'b0;
    tick(); mem_abc_in = LINE_A5; mem_abc_valid_in = 1'b1;
    tick();
    checks++; if (resp_abc_out !== LINE_A5) begin errors++; $display("FAIL wrb_abc: got %h required %h", resp_abc_out, LINE_A5); end
    checks++; if (resp_valid_out !== 2'b10) begin errors++; $display("FAIL wrb_resp_valid: got %b required 10", resp_valid_out); end
    mem_abc_valid_in = 1'b0; mem_abc_in = '0; mem_idle_in = 1'b1;
    tick();
    checks++; if (resp_valid_out !== 2'b00 || resp_abc_out !== LINE_A5) begin
      errors++; $display("FAIL wrb_resp_hold: got valid=%b abc=%h required valid=00 abc=%h", resp_valid_out, resp_abc_out, LINE_A5); end
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL wrb_done: got busy=%b required 0", busy_out); end
  endtask

  task automatic test_coincident_response();
    req_instr_in[0 +: IW] = 32'h8000_0010; req_valid_in = 2'b01; #1;
    wait_ready("coin");
    tick();
    req_valid_in = '0; mem_abc_in = 96'h1; mem_abc_valid_in = 1'b1;
    tick();
    checks++; if (resp_valid_out !== 2'b00 || resp_abc_out !== LINE_A5) begin
      errors++; $display("FAIL issue_abc_ignored: got valid=%b abc=%h required valid=00 abc=%h", resp_valid_out, resp_abc_out, LINE_A5); end
    mem_abc_valid_in = 1'b0; mem_idle_in = 1'b0;
    tick();
    mem_abc_in = LINE_CO; mem_abc_valid_in = 1'b1; mem_idle_in = 1'b1;
    tick();
    mem_abc_valid_in = 1'b0;
    checks++; if (resp_valid_out !== 2'b01 || resp_abc_out !== LINE_CO) begin
      errors++; $display("FAIL coin_resp: got valid=%b abc=%h required valid=01 abc=%h", resp_valid_out, resp_abc_out, LINE_CO); end
    checks++; if (busy_out !== 1'b0 || grant_out !== 2'b00) begin
      errors++; $display("FAIL coin_done: got busy=%b grant=%b required busy=0 grant=00", busy_out, grant_out); end
    tick();
    checks++; if (resp_valid_out !== 2'b00) begin errors++; $display("FAIL coin_resp_len: got %b required 00", resp_valid_out); end
  endtask

  task automatic test_drop();
    req_instr_in[0 +: IW] = 32'h0000_0000; req_valid_in = 2'b01; #1;
    wait_ready("drop");
    checks++; if (req_ready_out !== 2'b01) begin errors++; $display("FAIL drop_ready: got %b required 01", req_ready_out); end
    pulse_cnt = 0;
    tick();
    checks++; if (mem_instr_valid_out !== 1'b0 || busy_out !== 1'b0 || grant_out !== 2'b00) begin
      errors++; $display("FAIL drop_idle: got pulse=%b busy=%b grant=%b required 0 0 00", mem_instr_valid_out, busy_out, grant_out); end
    checks++; if (mem_instr_out !== 32'h0000_0000) begin errors++; $display("FAIL drop_latch: got %h required 00000000", mem_instr_out); end
    checks++; if (req_ready_out !== 2'b01) begin errors++; $display("FAIL drop_reaccept: got %b required 01", req_ready_out); end
    req_valid_in = '0;
    repeat (2) tick();
    checks++; if (pulse_cnt != 0) begin errors++; $display("FAIL drop_no_pulse: got %0d pulses required 0", pulse_cnt); end
  endtask

  task automatic test_timeout();
    int n = 0;
    req_instr_in[0 +: IW] = 32'h6000_0055; req_valid_in = 2'b01; mem_idle_in = 1'b1; #1;
    wait_ready("tmo");
    tick();
    req_valid_in = '0;
    checks++; if (mem_instr_valid_out !== 1'b1) begin errors++; $display("FAIL tmo_pulse: got %b required 1", mem_instr_valid_out); end
    while (!timeout_err_out && n < 100) begin
      tick();
      n++;
    end
    // ISSUE edge plus 64 counted wait cycles.
    checks++; if (n != TO + 1) begin errors++; $display("FAIL tmo_latency: got %0d cycles required %0d", n, TO + 1); end
    checks++; if (busy_out !== 1'b0 || grant_out !== 2'b00 || resp_valid_out !== 2'b00) begin
      errors++; $display("FAIL tmo_idle: got busy=%b grant=%b resp=%b required 0 00 00", busy_out, grant_out, resp_valid_out); end
    repeat (3) tick();
    checks++; if (timeout_err_out !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b required 1", timeout_err_out); end
  endtask

  task automatic test_async_reset();
    req_instr_in[IW +: IW] = 32'h6000_0077; req_valid_in = 2'b10; #1;
    wait_ready("arst");
    tick();
    req_valid_in = '0;
    tick(); mem_idle_in = 1'b0;
    tick();
    checks++; if (busy_out !== 1'b1 || grant_out !== 2'b10) begin
      errors++; $display("FAIL arst_pre: got busy=%b grant=%b required busy=1 grant=10", busy_out, grant_out); end
    mem_abc_in = LINE_A5; mem_abc_valid_in = 1'b1;
    #2; rst_in = 1'b1; #1;
    checks++; if ({req_ready_out, mem_instr_valid_out, resp_valid_out, grant_out, busy_out, timeout_err_out} !== '0) begin
      errors++; $display("FAIL arst_ctrl: got %b required 0", {req_ready_out, mem_instr_valid_out, resp_valid_out, grant_out, busy_out, timeout_err_out}); end
    checks++; if (mem_instr_out !== '0 || resp_abc_out !== '0) begin
      errors++; $display("FAIL arst_data: got instr=%h abc=%h required 0", mem_instr_out, resp_abc_out); end
    mem_abc_valid_in = 1'b0; mem_abc_in = '0; mem_idle_in = 1'b1;
    @(negedge clk_in); rst_in = 1'b0;
    pulse_cnt = 0;
    repeat (5) tick();
    checks++; if (pulse_cnt != 0 || busy_out !== 1'b0 || resp_abc_out !== '0) begin
      errors++; $display("FAIL arst_after: got pulses=%0d busy=%b abc=%h required 0 0 0", pulse_cnt, busy_out, resp_abc_out); end
  endtask

  initial begin
    test_reset();
    test_single_sma();
    test_round_robin();
    test_writeb_response();
    test_coincident_response();
    test_drop();
    test_timeout();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_instr_arbiter.md
Name: mem_instr_arbiter

Overview:
- Shares the single instruction port of the data-cache memory unit between NUM_REQ requesters, e.g. the instruction decoder and the FMA writeback path.
- Accepts one memory instruction at a time using a round-robin grant.
- Issues the instruction to the memory unit as a one-cycle valid pulse, then tracks the unit's idle/busy handshake to completion.
- Routes any returned abc line back to the requester that issued the instruction, and flags hung transactions through a timeout.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- INSTRUCTION_WIDTH, 32, bits per instruction. Opcode is instr[31:28], i.e. the first 4 bits, MSB-first.
- LINE_WIDTH, 96, width of the abc line returned by memory.
- TIMEOUT_CYCLES, 64, maximum cycles from issue to memory idle before the transaction is abandoned.

Ports:
- clk_in  input  1  clock, rising edge.
- rst_in  input  1  reset, asynchronous, active-high.
- req_instr_in  input  NUM_REQ*INSTRUCTION_WIDTH  requester i's instruction in slice [i*IW +: IW].
- req_valid_in  input  NUM_REQ  requester i has an instruction pending; held until accepted.
- req_ready_out  output  NUM_REQ  one-hot accept; transfer occurs when valid and ready are both high.
- mem_instr_out  output  INSTRUCTION_WIDTH  instruction presented to the memory unit.
- mem_instr_valid_out  output  1  one-cycle issue pulse to the memory unit.
- mem_idle_in  input  1  memory unit idle flag (1 = idle).
- mem_abc_in  input  LINE_WIDTH  abc line from the memory unit.
- mem_abc_valid_in  input  1  mem_abc_in is valid this cycle.
- resp_abc_out  output  LINE_WIDTH  registered copy of the last returned abc line.
- resp_valid_out  output  NUM_REQ  one-cycle pulse on the owning requester's bit when resp_abc_out updates.
- grant_out  output  NUM_REQ  one-hot owner of the current transaction; 0 when in IDLE.
- busy_out  output  1  high in every state except IDLE.
- timeout_err_out  output  1  sticky; set on timeout, cleared only by reset.

Behaviour:
- Reset, asynchronous: state=IDLE, rr_ptr=0, all outputs 0, timeout counter 0.
- Reset mid-transaction aborts it immediately. No further pulses are issued and no response is delivered.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_IDLE.
- Winner selection (combinational, IDLE only): the first i with req_valid_in[i]=1, searching from rr_ptr upward and wrapping modulo NUM_REQ.
- req_ready_out[winner]=1 only when state=IDLE and mem_idle_in=1. All other bits are 0.
- IDLE, on a transfer:
  - Latch the winner's instruction into mem_instr_out.
  - Set grant_out to the one-hot winner.
  - Set rr_ptr to (winner+1) mod NUM_REQ.
  - Opcode in {0110 SMA, 0111 LOADI, 1000 LOADB, 1001 WRITEB}: go to ISSUE.
  - Any other opcode: accept and drop. No memory pulse is issued; next cycle is IDLE with grant_out=0.
- ISSUE: mem_instr_valid_out=1 for exactly this cycle. Clear the timeout counter. Go to WAIT_BUSY.
- WAIT_BUSY: advance to WAIT_IDLE once mem_idle_in=0.
- WAIT_IDLE: return to IDLE once mem_idle_in=1. Clear grant_out on that transition.
- Response capture: mem_abc_valid_in=1 in WAIT_BUSY or WAIT_IDLE does the following on the next cycle:
  - Register mem_abc_in into resp_abc_out.
  - Pulse resp_valid_out equal to grant_out for one cycle.
- mem_abc_valid_in in IDLE or ISSUE is ignored.
- If mem_abc_valid_in coincides with the mem_idle_in rise in WAIT_IDLE, the response is still delivered to the owning requester.
- Timeout: the counter increments every cycle in WAIT_BUSY and WAIT_IDLE.
  - When it reaches TIMEOUT_CYCLES-1 without completion: set timeout_err_out, go to IDLE, clear grant_out.
  - No response is pulsed on a timeout.
- Throughput: at most one memory instruction in flight. Minimum 4 cycles per issued instruction (IDLE accept, ISSUE, WAIT_BUSY, WAIT_IDLE).
- Requests arriving while busy stay pending. req_ready_out stays 0 until the next IDLE with mem_idle_in=1.
- A requester dropping req_valid_in before acceptance is legal, and that requester is simply skipped.
- rr_ptr advances only on a transfer, so a requester cannot starve.
- mem_instr_out holds its value between transactions; its value is only meaningful when mem_instr_valid_out=1.

Test Plan:
- Reset then idle: rst_in=1 → all outputs 0. No req_valid_in → mem_instr_valid_out stays 0 for 20 cycles.
- Single SMA: req 0 sends 0x6001_2300, memory drops idle 1 cycle after the pulse and raises it 2 cycles later → exactly one mem_instr_valid_out pulse with mem_instr_out=0x60012300. grant_out=01 throughout the transaction, busy_out=0 after completion.
- Round robin: both requesters hold valid continuously → accepts alternate 0,1,0,1 across 4 transactions. Each req_ready_out pulse lasts 1 cycle.
- WRITEB response: req 1 sends opcode 1001, memory asserts mem_abc_valid_in with 96'hA5A5... during WAIT_IDLE → resp_abc_out=96'hA5A5... and resp_valid_out=10 for 1 cycle.
- Drop path: req 0 sends NOP 0x0000_0000 → accepted, no mem_instr_valid_out pulse, back in IDLE next cycle.
- Timeout and reset: memory holds mem_idle_in=1 after issue → timeout_err_out=1 after 64 cycles, back in IDLE. Asynchronous rst_in mid-WAIT_IDLE → outputs 0 immediately, with no clock edge required.
